// File: rtl/fxp_to_bcd.sv
// Signed two's-complement word to sign-magnitude BCD: serial double-dabble for integer digits,
// serial multiply-by-10 for fraction digits. Define BCD_ROUND_EN to round the fraction LSD.
module fxp_to_bcd #(
    parameter int unsigned M           = 32,
    parameter int unsigned I_FRAC      = 8,
    parameter int unsigned INT_DIGITS  = 7,
    parameter int unsigned FRAC_DIGITS = 7
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic [M-1:0]                             i_val,
    input  logic                                     i_fixed,
    input  logic                                     i_valid,
    output logic                                     o_ready,
    output logic [4*(1+INT_DIGITS+FRAC_DIGITS)-1:0]  o_bcd,
    output logic                                     o_valid,
    input  logic                                     i_ready,
    output logic                                     is_signed,
    output logic                                     is_fixed,
    output logic                                     o_overflow
);

    // Scratch digits cover 2^M; at least one digit above INT_DIGITS for overflow detection
    localparam int unsigned SCR_BASE   = (M * 301) / 1000 + 1;
    localparam int unsigned SCR_DIGITS = (SCR_BASE > INT_DIGITS) ? SCR_BASE : INT_DIGITS + 1;
`ifdef BCD_ROUND_EN
    localparam int unsigned FD_N = FRAC_DIGITS + 1;
`else
    localparam int unsigned FD_N = FRAC_DIGITS;
`endif
    localparam int unsigned CNT_W = $clog2(M + FD_N + 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StIntConv, StFracConv, StRound, StOut
    } state_e;

    state_e                    state;
    logic [M-1:0]              val_q;
    logic                      fixed_q;
    logic [M-1:0]              bin_q;
    logic [4*SCR_DIGITS-1:0]   scr_q;
    logic [I_FRAC-1:0]         frac_q;
    logic [4*FD_N-1:0]         fdig_q;
    logic [CNT_W-1:0]          cnt_q;

    logic [M-1:0]              mag;
    logic [M-1:0]              mag_int;
    logic [I_FRAC-1:0]         mag_frac;
    logic [4*SCR_DIGITS-1:0]   scr_adj;
    logic [4*SCR_DIGITS-1:0]   scr_shift;
    logic [I_FRAC+3:0]         prod;
    logic [4*FD_N-1:0]         fdig_next;
    logic [4*SCR_DIGITS-1:0]   fin_int;
    logic [4*FRAC_DIGITS-1:0]  fin_frac;
    logic                      fin_carry;
    logic                      fin_ovf;
    logic [4*INT_DIGITS-1:0]   fin_int_out;
    logic                      fin_neg;
    logic                      finish;
    logic                      int_last;
    logic                      frac_last;

    assign o_ready = (state == StIdle);

    always_comb begin
        mag      = val_q[M-1] ? (~val_q + M'(1)) : val_q;
        // Integer field left-aligned so the dabble always consumes bin_q[M-1]
        mag_int  = fixed_q ? {mag[M-1:I_FRAC], {I_FRAC{1'b0}}} : mag;
        mag_frac = fixed_q ? mag[I_FRAC-1:0] : '0;
    end

    always_comb begin
        scr_adj = scr_q;
        for (int i = 0; i < SCR_DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        end
    end

    assign scr_shift = {scr_adj[4*SCR_DIGITS-2:0], bin_q[M-1]};
    assign prod      = ({4'b0, frac_q} << 3) + ({4'b0, frac_q} << 1);
    assign fdig_next = {fdig_q[4*FD_N-5:0], prod[I_FRAC+3:I_FRAC]};

    assign int_last  = (cnt_q == (fixed_q ? CNT_W'(M - I_FRAC - 1) : CNT_W'(M - 1)));
    assign frac_last = (cnt_q == CNT_W'(FD_N - 1));

`ifdef BCD_ROUND_EN
    logic [4*FRAC_DIGITS-1:0] rnd_frac;
    logic [4*INT_DIGITS-1:0]  rnd_int;
    logic                     rnd_carry;

    // Guard digit sits in the lowest nibble; carry ripples frac LSD up through integer digits
    always_comb begin
        logic       c;
        logic [3:0] d;
        c        = (fdig_q[3:0] >= 4'd5);
        rnd_frac = '0;
        rnd_int  = '0;
        for (int i = 0; i < FRAC_DIGITS; i++) begin
            d = fdig_q[4*(i+1) +: 4];
            if (c) begin
                if (d == 4'd9) d = 4'd0;
                else begin
                    d = d + 4'd1;
                    c = 1'b0;
                end
            end
            rnd_frac[4*i +: 4] = d;
        end
        for (int i = 0; i < INT_DIGITS; i++) begin
            d = scr_q[4*i +: 4];
            if (c) begin
                if (d == 4'd9) d = 4'd0;
                else begin
                    d = d + 4'd1;
                    c = 1'b0;
                end
            end
            rnd_int[4*i +: 4] = d;
        end
        rnd_carry = c;
    end

    assign finish = (state == StIntConv && int_last && !fixed_q) || (state == StRound);
`else
    assign finish = (state == StIntConv && int_last && !fixed_q) ||
                    (state == StFracConv && frac_last);
`endif

    // Result is formed from the values being written on the finishing edge
    always_comb begin
        fin_int   = scr_shift;
        fin_frac  = '0;
        fin_carry = 1'b0;
        if (state == StFracConv) begin
            fin_int  = scr_q;
            fin_frac = fdig_next[4*FD_N-1 -: 4*FRAC_DIGITS];
        end
`ifdef BCD_ROUND_EN
        if (state == StRound) begin
            fin_int   = {scr_q[4*SCR_DIGITS-1:4*INT_DIGITS], rnd_int};
            fin_frac  = rnd_frac;
            fin_carry = rnd_carry;
        end
`endif
        fin_ovf     = (|fin_int[4*SCR_DIGITS-1:4*INT_DIGITS]) | fin_carry;
        fin_int_out = fin_ovf ? {INT_DIGITS{4'h9}} : fin_int[4*INT_DIGITS-1:0];
        fin_neg     = val_q[M-1] && ((fin_int_out != '0) || (fin_frac != '0));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= StIdle;
            val_q      <= '0;
            fixed_q    <= 1'b0;
            bin_q      <= '0;
            scr_q      <= '0;
            frac_q     <= '0;
            fdig_q     <= '0;
            cnt_q      <= '0;
            o_bcd      <= '0;
            o_valid    <= 1'b0;
            is_signed  <= 1'b0;
            is_fixed   <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (i_valid) begin
                        val_q   <= i_val;
                        fixed_q <= i_fixed;
                        state   <= StLoad;
                    end
                end
                StLoad: begin
                    bin_q  <= mag_int;
                    frac_q <= mag_frac;
                    scr_q  <= '0;
                    fdig_q <= '0;
                    cnt_q  <= '0;
                    state  <= StIntConv;
                end
                StIntConv: begin
                    scr_q <= scr_shift;
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (int_last) begin
                        cnt_q <= '0;
                        state <= fixed_q ? StFracConv : StOut;
                    end
                end
                StFracConv: begin
                    frac_q <= prod[I_FRAC-1:0];
                    fdig_q <= fdig_next;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (frac_last) begin
                        cnt_q <= '0;
`ifdef BCD_ROUND_EN
                        state <= StRound;
`else
                        state <= StOut;
`endif
                    end
                end
`ifdef BCD_ROUND_EN
                StRound: state <= StOut;
`endif
                StOut: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase

            if (finish) begin
                o_bcd      <= {fin_neg ? 4'hF : 4'h0, fin_int_out, fin_frac};
                is_signed  <= fin_neg;
                is_fixed   <= fixed_q;
                o_overflow <= fin_ovf;
                o_valid    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fxp_to_bcd.sv
// Directed self-checking bench for fxp_to_bcd (default parameters, either rounding build).
module tb_fxp_to_bcd;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] i_val = '0;
    logic        i_fixed = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_ready;
    logic [63:0] o_bcd;
    logic        o_valid;
    logic        is_signed;
    logic        is_fixed;
    logic        o_overflow;

    int errors = 0;
    int checks = 0;

    localparam int LAT_INT = 33;
`ifdef BCD_ROUND_EN
    localparam int          LAT_FIX   = 34;
    localparam logic [63:0] EXP_NEGFR = 64'hF_0000000_0039063;
    localparam logic [63:0] EXP_MAXP  = 64'h0_8388607_9960938;
`else
    localparam int          LAT_FIX   = 32;
    localparam logic [63:0] EXP_NEGFR = 64'hF_0000000_0039062;
    localparam logic [63:0] EXP_MAXP  = 64'h0_8388607_9960937;
`endif

    fxp_to_bcd dut (
        .CLK        (CLK),
        .RST        (RST),
        .i_val      (i_val),
        .i_fixed    (i_fixed),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_bcd      (o_bcd),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .is_signed  (is_signed),
        .is_fixed   (is_fixed),
        .o_overflow (o_overflow)
    );

    always #5 CLK = ~CLK;

    // Presents one input, then counts edges after the accepting edge until o_valid (bounded)
    task automatic run_conv(input logic [31:0] v, input logic f, output int lat);
        @(negedge CLK);
        i_val   = v;
        i_fixed = f;
        i_valid = 1'b1;
        @(posedge CLK);
        #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 200) begin
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge CLK);
        i_ready = 1'b1;
        @(posedge CLK);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({o_bcd, o_valid, is_signed, is_fixed, o_overflow, o_ready} !== {64'h0, 5'b00001}) begin
            errors++;
            $display("FAIL reset_outputs: got bcd=%h v=%b s=%b f=%b ov=%b rdy=%b want 0,0,0,0,0,1",
                     o_bcd, o_valid, is_signed, is_fixed, o_overflow, o_ready);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_fixed_half();
        int lat;
        run_conv(32'h0000_0180, 1'b1, lat);
        checks++;
        if (lat !== LAT_FIX) begin
            errors++;
            $display("FAIL half_latency: got %0d want %0d", lat, LAT_FIX);
        end
        checks++;
        if ({o_bcd, is_signed, is_fixed, o_overflow} !== {64'h0_0000001_5000000, 3'b010}) begin
            errors++;
            $display("FAIL half_result: got %h s=%b f=%b ov=%b want 000000015000000 0 1 0",
                     o_bcd, is_signed, is_fixed, o_overflow);
        end
        release_result();
    endtask

    task automatic test_int_negative();
        int lat;
        run_conv(32'hFFFF_FB2E, 1'b0, lat);
        checks++;
        if (lat !== LAT_INT) begin
            errors++;
            $display("FAIL neg1234_latency: got %0d want %0d", lat, LAT_INT);
        end
        checks++;
        if ({o_bcd, is_signed, is_fixed, o_overflow} !== {64'hF_0001234_0000000, 3'b100}) begin
            errors++;
            $display("FAIL neg1234_result: got %h s=%b f=%b ov=%b want F00012340000000 1 0 0",
                     o_bcd, is_signed, is_fixed, o_overflow);
        end
        release_result();
    endtask

    task automatic test_fixed_values();
        int lat;
        run_conv(32'hFFFF_FFFF, 1'b1, lat);
        checks++;
        if (lat !== LAT_FIX) begin
            errors++;
            $display("FAIL negfrac_latency: got %0d want %0d", lat, LAT_FIX);
        end
        checks++;
        if ({o_bcd, is_signed, o_overflow} !== {EXP_NEGFR, 2'b10}) begin
            errors++;
            $display("FAIL negfrac_result: got %h s=%b ov=%b want %h 1 0",
                     o_bcd, is_signed, o_overflow, EXP_NEGFR);
        end
        release_result();
        run_conv(32'h7FFF_FFFF, 1'b1, lat);
        checks++;
        if ({o_bcd, is_signed, o_overflow} !== {EXP_MAXP, 2'b00}) begin
            errors++;
            $display("FAIL maxpos_fixed: got %h s=%b ov=%b want %h 0 0",
                     o_bcd, is_signed, o_overflow, EXP_MAXP);
        end
        release_result();
        run_conv(32'h0000_0000, 1'b0, lat);
        checks++;
        if ({o_bcd, is_signed, o_overflow, lat} !== {64'h0, 2'b00, LAT_INT}) begin
            errors++;
            $display("FAIL zero_int: got %h s=%b ov=%b lat=%0d want 0 0 0 %0d",
                     o_bcd, is_signed, o_overflow, lat, LAT_INT);
        end
        release_result();
    endtask

    task automatic test_overflow();
        int lat;
        run_conv(32'd12345678, 1'b0, lat);
        checks++;
        if ({o_bcd, is_signed, o_overflow} !== {64'h0_9999999_0000000, 2'b01}) begin
            errors++;
            $display("FAIL ovf_pos: got %h s=%b ov=%b want 099999990000000 0 1",
                     o_bcd, is_signed, o_overflow);
        end
        release_result();
        run_conv(32'h8000_0000, 1'b0, lat);
        checks++;
        if ({o_bcd, is_signed, o_overflow, lat} !== {64'hF_9999999_0000000, 2'b11, LAT_INT}) begin
            errors++;
            $display("FAIL ovf_minint: got %h s=%b ov=%b lat=%0d want F99999990000000 1 1 %0d",
                     o_bcd, is_signed, o_overflow, lat, LAT_INT);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_conv(32'h0000_0180, 1'b1, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            i_val   = 32'h1234_0000 + 32'(i);
            i_valid = ~i_valid;
            @(posedge CLK);
            #1;
            checks++;
            if ({o_valid, o_ready, o_bcd} !== {2'b10, 64'h0_0000001_5000000}) begin
                errors++;
                $display("FAIL hold_cycle%0d: got v=%b rdy=%b bcd=%h want 1 0 000000015000000",
                         i, o_valid, o_ready, o_bcd);
            end
        end
        @(negedge CLK);
        i_valid = 1'b0;
        release_result();
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            errors++;
            $display("FAIL release: got v=%b rdy=%b want 0 1", o_valid, o_ready);
        end
        run_conv(32'hFFFF_FB2E, 1'b0, lat);
        checks++;
        if ({o_bcd, is_signed, lat} !== {64'hF_0001234_0000000, 1'b1, LAT_INT}) begin
            errors++;
            $display("FAIL after_hold: got %h s=%b lat=%0d want F00012340000000 1 %0d",
                     o_bcd, is_signed, lat, LAT_INT);
        end
    endtask

    task automatic test_reset_midconv();
        int lat;
        release_result();
        @(negedge CLK);
        i_val   = 32'h8000_0000;
        i_fixed = 1'b0;
        i_valid = 1'b1;
        @(posedge CLK);
        #1;
        i_valid = 1'b0;
        repeat (10) @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        checks++;
        if ({o_bcd, o_valid, is_signed, is_fixed, o_overflow, o_ready} !== {64'h0, 5'b00001}) begin
            errors++;
            $display("FAIL midconv_reset: got bcd=%h v=%b s=%b f=%b ov=%b rdy=%b want 0,0,0,0,0,1",
                     o_bcd, o_valid, is_signed, is_fixed, o_overflow, o_ready);
        end
        @(negedge CLK);
        RST = 1'b0;
        run_conv(32'h0000_0180, 1'b1, lat);
        checks++;
        if ({o_bcd, is_signed, is_fixed, o_overflow, lat} !==
            {64'h0_0000001_5000000, 3'b010, LAT_FIX}) begin
            errors++;
            $display("FAIL post_reset_half: got %h s=%b f=%b ov=%b lat=%0d want 000000015000000",
                     o_bcd, is_signed, is_fixed, o_overflow, lat);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_fixed_half();
        test_int_negative();
        test_fixed_values();
        test_overflow();
        test_back_to_back();
        test_reset_midconv();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fxp_to_bcd.md
# fxp_to_bcd

Parametrised, handshaked converter from a signed two's-complement result word to sign-magnitude BCD for the calculator display path. It sits between the ALU result register and the display driver. Integer digits use serial double-dabble and fraction digits use serial multiply-by-10. Digit counts, fraction width and integer/fixed mode are configurable, and integer overflow is reported and saturated.

## Interface
- M, 32, input word width (bits)
- I_FRAC, 8, fraction bits in fixed mode (1..M-1)
- INT_DIGITS, 7, integer BCD digits output
- FRAC_DIGITS, 7, fraction BCD digits output
- Derived: BCD_WIDTH = 4*(1+INT_DIGITS+FRAC_DIGITS); W_INT = fixed ? M-I_FRAC : M

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- i_val  in  M  two's-complement input
- i_fixed  in  1  1 = fixed-point (I_FRAC fraction bits), 0 = integer
- i_valid  in  1  input request
- o_ready  out  1  block can accept; high exactly in IDLE
- o_bcd  out  BCD_WIDTH  [top nibble] sign (F = negative, 0 = positive), then INT_DIGITS integer digits MSD first, then FRAC_DIGITS fraction digits
- o_valid  out  1  o_bcd and flags valid
- i_ready  in  1  downstream accepts result
- is_signed  out  1  result negative (matches sign nibble)
- is_fixed  out  1  captured i_fixed
- o_overflow  out  1  integer magnitude exceeded INT_DIGITS; integer digits saturated

## Operation
- States: IDLE, LOAD, INT_CONV, FRAC_CONV, [ROUND], OUT.
- IDLE: o_ready=1. A transfer occurs when i_valid && o_ready. On that edge, i_val and i_fixed are captured and the state moves to LOAD. Later changes on i_val are ignored.
- LOAD (1 cycle): magnitude = MSB ? ~i_val+1 : i_val, treated as M-bit unsigned; -2^(M-1) is therefore exact. The integer field is magnitude[M-1:I_FRAC] when fixed, else the full magnitude. The fraction field is magnitude[I_FRAC-1:0] when fixed, else 0.
- INT_CONV (W_INT cycles): one double-dabble shift per cycle. Each digit gets +3 when ≥5, then the register shifts. The scratch register holds enough digits for 2^M; the upper digits are used for overflow detection.
- FRAC_CONV (fixed only, FRAC_DIGITS cycles): each cycle, frac = frac*10. The bits above I_FRAC form the next digit, MSD first, and the remainder is kept. Integer mode skips this state and its fraction digits are 0.
- Overflow: if any scratch digit above INT_DIGITS is nonzero, o_overflow=1 and all integer digits are 9. Fraction digits are still produced.
- Negative zero: if the input is negative and every output digit is 0, the sign nibble is 0 and is_signed=0.
- OUT: o_valid=1, and o_bcd and flags are held stable until i_ready. On an edge with o_valid && i_ready, the state returns to IDLE and o_valid clears. A new input is accepted in the following IDLE cycle at the earliest; there is no overlap.
- i_valid is ignored in every state except IDLE.

## Timing
- Reset values: o_bcd=0, o_valid=0, is_signed=0, is_fixed=0, o_overflow=0, state IDLE, o_ready=1.
- Reset mid-conversion aborts immediately with the above values. No partial result is ever presented.
- o_ready is decoded combinationally from state. All other outputs are registered.
- Latency: o_valid rises on edge 1+W_INT+F after the accepting edge.
  - Integer mode: F = 0.
  - Fixed mode: F = FRAC_DIGITS, or FRAC_DIGITS+2 with rounding enabled.
  - Defaults: integer 33, fixed 32 (rounding: 34).
- Throughput: one result per latency + 2 cycles with i_ready held high.

## Configuration
- BCD_ROUND_EN defined:
  - Fixed mode computes one extra guard digit in FRAC_CONV, then a 1-cycle ROUND state.
  - Guard digit ≥5 adds 1 to the LSD. The carry ripples through the fraction digits into the integer digits.
  - A carry out of the top integer digit sets o_overflow and saturates the integer digits to 9.
- BCD_ROUND_EN undefined: fraction digits are truncated, the ROUND state and guard digit are absent, and F = FRAC_DIGITS.
- Integer mode is identical in both builds.

## Test plan
- Fixed, i_val=0x00000180 (1.5) -> sign 0, int 0000001, frac 5000000, o_valid on edge 32, o_overflow=0.
- Integer, i_val=0xFFFFFB2E (-1234) -> sign F, is_signed=1, int 0001234, frac 0000000, o_valid on edge 33.
- Integer, i_val=12345678 -> int 9999999, o_overflow=1, sign 0. Also i_val=0x80000000 -> o_overflow=1, sign F, no hang.
- Fixed, i_val=0xFFFFFFFF (-0.00390625) -> sign F, int 0000000, frac 0039062. With BCD_ROUND_EN: frac 0039063, o_valid on edge 34.
- Backpressure: hold i_ready=0 for 10 cycles in OUT while pulsing i_valid with a new value -> o_valid=1, o_bcd unchanged, o_ready=0. Then pulse i_ready -> o_valid=0 and o_ready=1 after that edge, and the next input converts correctly.
- Assert RST during INT_CONV -> all outputs take their reset values asynchronously and the state is IDLE. A subsequent 1.5 conversion gives the same result as the first scenario.
